// File: rtl/rr_writeback_pkg.sv
// Shared types and constants for the record-trace AXI writeback controller.
package rr_writeback_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } wb_state_e;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  function automatic int unsigned bytes_per_beat(input int unsigned axi_width);
    return axi_width / 8;
  endfunction

endpackage

// File: rtl/rr_trace_writeback_ctrl.sv
// Drains the merged record-trace FIFO into a linear DRAM log buffer over AXI4
// write bursts, one burst outstanding, with a short flush burst on finish.
module rr_trace_writeback_ctrl
  import rr_writeback_pkg::*;
#(
  parameter int unsigned AXI_WIDTH      = 512,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned OFFSET_WIDTH   = 32,
  parameter int unsigned BURST_BEATS    = 16,
  parameter int unsigned FIFO_CNT_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        sync_rst,
  input  logic                        cfg_start,
  input  logic [AXI_ADDR_WIDTH-1:0]   cfg_buf_base,
  input  logic [OFFSET_WIDTH-1:0]     cfg_buf_size,
  input  logic                        record_finish,
  input  logic [AXI_WIDTH-1:0]        record_out_fifo_dout,
  input  logic [OFFSET_WIDTH-1:0]     record_out_fifo_dout_size,
  input  logic                        record_out_fifo_empty,
  input  logic [FIFO_CNT_WIDTH-1:0]   record_out_fifo_cnt,
  output logic                        record_out_fifo_rd_en,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [AXI_ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        wvalid,
  input  logic                        wready,
  output logic [AXI_WIDTH-1:0]        wdata,
  output logic [AXI_WIDTH/8-1:0]      wstrb,
  output logic                        wlast,
  input  logic                        bvalid,
  output logic                        bready,
  input  logic [1:0]                  bresp,
  output logic                        busy,
  output logic                        done,
  output logic                        buf_full,
  output logic                        resp_err,
  output logic [OFFSET_WIDTH-1:0]     bytes_written,
  output logic [63:0]                 bits_logged
);

  localparam int unsigned BPB         = bytes_per_beat(AXI_WIDTH);
  localparam logic [2:0]  AXSIZE      = 3'($clog2(BPB));
  localparam logic [7:0]  BURST_LEN   = 8'(BURST_BEATS);

  wb_state_e                   state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   base_q, base_d;
  logic [OFFSET_WIDTH-1:0]     size_q, size_d;
  logic                        finish_seen_q, finish_seen_d;
  logic                        awvalid_q, awvalid_d;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [7:0]                  awlen_q, awlen_d;
  logic [7:0]                  len_q, len_d;
  logic [7:0]                  beat_cnt_q, beat_cnt_d;
  logic [OFFSET_WIDTH-1:0]     bytes_written_q, bytes_written_d;
  logic [63:0]                 bits_logged_q, bits_logged_d;
  logic                        done_q, done_d;
  logic                        buf_full_q, buf_full_d;
  logic                        resp_err_q, resp_err_d;

  logic                        burst_go;
  logic [7:0]                  burst_len;

  assign awvalid       = awvalid_q;
  assign awaddr        = awaddr_q;
  assign awlen         = awlen_q;
  assign awsize        = AXSIZE;
  assign awburst       = AXI_BURST_INCR;
  assign wdata         = record_out_fifo_dout;
  assign wstrb         = '1;
  assign done          = done_q;
  assign buf_full      = buf_full_q;
  assign resp_err      = resp_err_q;
  assign bytes_written = bytes_written_q;
  assign bits_logged   = bits_logged_q;

  // Next-state and handshake decode
  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    size_d          = size_q;
    finish_seen_d   = finish_seen_q;
    awvalid_d       = awvalid_q;
    awaddr_d        = awaddr_q;
    awlen_d         = awlen_q;
    len_d           = len_q;
    beat_cnt_d      = beat_cnt_q;
    bytes_written_d = bytes_written_q;
    bits_logged_d   = bits_logged_q;
    done_d          = done_q;
    buf_full_d      = buf_full_q;
    resp_err_d      = resp_err_q;
    burst_go        = 1'b0;
    burst_len       = BURST_LEN;

    wvalid                = (state_q == ST_W) && !record_out_fifo_empty;
    record_out_fifo_rd_en = wvalid && wready;
    wlast                 = (state_q == ST_W) && (beat_cnt_q == len_q - 8'd1);
    bready                = (state_q == ST_B);
    busy                  = (state_q != ST_IDLE) && (state_q != ST_DONE);

    if (state_q != ST_IDLE && record_finish) begin
      finish_seen_d = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cfg_start) begin
          base_d          = cfg_buf_base;
          size_d          = cfg_buf_size;
          bytes_written_d = '0;
          bits_logged_d   = '0;
          done_d          = 1'b0;
          buf_full_d      = 1'b0;
          resp_err_d      = 1'b0;
          finish_seen_d   = 1'b0;
          state_d         = ST_ARB;
        end
      end
      ST_ARB: begin
        if (bytes_written_q == size_q && !record_out_fifo_empty) begin
          buf_full_d = 1'b1;
          done_d     = 1'b1;
          state_d    = ST_DONE;
        end else if (record_out_fifo_cnt >= FIFO_CNT_WIDTH'(BURST_BEATS)) begin
          burst_go  = 1'b1;
          burst_len = BURST_LEN;
        end else if (finish_seen_q && !record_out_fifo_empty) begin
          // Count is below a full burst here; a zero count on a non-empty FWFT head still moves one beat
          burst_go  = 1'b1;
          burst_len = (record_out_fifo_cnt == '0) ? 8'd1 : 8'(record_out_fifo_cnt);
        end else if (finish_seen_q) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
        if (burst_go) begin
          awaddr_d   = base_q + AXI_ADDR_WIDTH'(bytes_written_q);
          awlen_d    = burst_len - 8'd1;
          len_d      = burst_len;
          beat_cnt_d = '0;
          awvalid_d  = 1'b1;
          state_d    = ST_AW;
        end
      end
      ST_AW: begin
        if (awready) begin
          awvalid_d = 1'b0;
          state_d   = ST_W;
        end
      end
      ST_W: begin
        if (record_out_fifo_rd_en) begin
          bits_logged_d = bits_logged_q + 64'(record_out_fifo_dout_size);
          beat_cnt_d    = beat_cnt_q + 8'd1;
          if (wlast) begin
            beat_cnt_d = '0;
            state_d    = ST_B;
          end
        end
      end
      ST_B: begin
        if (bvalid) begin
          bytes_written_d = bytes_written_q + OFFSET_WIDTH'(len_q) * OFFSET_WIDTH'(BPB);
          resp_err_d      = resp_err_q | (bresp != AXI_RESP_OKAY);
          state_d         = ST_ARB;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q         <= ST_IDLE;
      base_q          <= '0;
      size_q          <= '0;
      finish_seen_q   <= 1'b0;
      awvalid_q       <= 1'b0;
      awaddr_q        <= '0;
      awlen_q         <= '0;
      len_q           <= '0;
      beat_cnt_q      <= '0;
      bytes_written_q <= '0;
      bits_logged_q   <= '0;
      done_q          <= 1'b0;
      buf_full_q      <= 1'b0;
      resp_err_q      <= 1'b0;
    end else begin
      // A burst never outruns the FIFO since its length is bounded by the occupancy
      if (state_q == ST_W) assert (!record_out_fifo_empty);
      state_q         <= state_d;
      base_q          <= base_d;
      size_q          <= size_d;
      finish_seen_q   <= finish_seen_d;
      awvalid_q       <= awvalid_d;
      awaddr_q        <= awaddr_d;
      awlen_q         <= awlen_d;
      len_q           <= len_d;
      beat_cnt_q      <= beat_cnt_d;
      bytes_written_q <= bytes_written_d;
      bits_logged_q   <= bits_logged_d;
      done_q          <= done_d;
      buf_full_q      <= buf_full_d;
      resp_err_q      <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_rr_trace_writeback_ctrl.sv
// Directed bench: FWFT FIFO and AXI slave models around the writeback controller.
module tb_rr_trace_writeback_ctrl;

  logic         clk;
  logic         sync_rst;
  logic         cfg_start;
  logic [63:0]  cfg_buf_base;
  logic [31:0]  cfg_buf_size;
  logic         record_finish;
  logic [511:0] dout;
  logic [31:0]  dout_size;
  logic         empty;
  logic [9:0]   cnt;
  logic         rd_en;
  logic         awvalid, awready;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         wvalid, wready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         bvalid, bready;
  logic [1:0]   bresp;
  logic         busy, done, buf_full, resp_err;
  logic [31:0]  bytes_written;
  logic [63:0]  bits_logged;

  rr_trace_writeback_ctrl dut (
    .clk(clk), .sync_rst(sync_rst), .cfg_start(cfg_start),
    .cfg_buf_base(cfg_buf_base), .cfg_buf_size(cfg_buf_size),
    .record_finish(record_finish),
    .record_out_fifo_dout(dout), .record_out_fifo_dout_size(dout_size),
    .record_out_fifo_empty(empty), .record_out_fifo_cnt(cnt),
    .record_out_fifo_rd_en(rd_en),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .busy(busy), .done(done), .buf_full(buf_full), .resp_err(resp_err),
    .bytes_written(bytes_written), .bits_logged(bits_logged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] base;
    logic [31:0] size;
    int          nbeats;
    int          last_size;
    int          aw_delay;
    bit          wtoggle;
    int          err_burst;
    bit          stray;
    int          exp_bursts;
    int          exp_len0;
    int          exp_len1;
    logic [63:0] exp_addr0;
    logic [63:0] exp_addr1;
    logic [31:0] exp_bytes;
    logic [63:0] exp_bits;
    bit          exp_buf_full;
    bit          exp_resp_err;
    int          exp_left;
  } vec_t;

  vec_t vecs[5];

  int checks = 0;
  int failures = 0;

  logic [511:0] fq_data[$];
  logic [31:0]  fq_size[$];
  logic [511:0] exp_data[$];
  logic [511:0] wbeats_q[$];
  logic [63:0]  aw_addr_q[$];
  logic [7:0]   aw_len_q[$];
  int           wlast_q[$];

  int cyc, aw_wait, aw_delay, err_burst, burst_idx, nbeat, rd_viol, stab_viol;
  bit wtoggle, b_pending, aw_prev_valid;
  logic [63:0] aw_prev_addr;
  logic [7:0]  aw_prev_len;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    empty     = (fq_data.size() == 0);
    cnt       = 10'(fq_data.size());
    dout      = empty ? '0 : fq_data[0];
    dout_size = empty ? 32'd0 : fq_size[0];
  endtask

  // One clock: entered and left at the falling edge
  task automatic tick();
    bit hs_aw, hs_w, hs_b, rd, lw;
    drive_fifo();
    awready = awvalid && (aw_wait >= aw_delay);
    wready  = wtoggle ? cyc[0] : 1'b1;
    bvalid  = b_pending;
    bresp   = (b_pending && burst_idx == err_burst) ? 2'b10 : 2'b00;
    #1;
    if (rd_en !== (wvalid && wready)) rd_viol++;
    if (awvalid && aw_prev_valid && (awaddr !== aw_prev_addr || awlen !== aw_prev_len)) stab_viol++;
    aw_prev_valid = awvalid;
    aw_prev_addr  = awaddr;
    aw_prev_len   = awlen;
    hs_aw = awvalid && awready;
    hs_w  = wvalid && wready;
    hs_b  = bvalid && bready;
    rd    = rd_en;
    lw    = wlast;
    if (hs_aw) begin
      aw_addr_q.push_back(awaddr);
      aw_len_q.push_back(awlen);
      aw_wait = 0;
    end else if (awvalid) begin
      aw_wait++;
    end
    if (hs_w) begin
      wbeats_q.push_back(wdata);
      nbeat++;
      if (lw) wlast_q.push_back(nbeat);
    end
    @(posedge clk);
    @(negedge clk);
    if (rd && fq_data.size() > 0) begin
      void'(fq_data.pop_front());
      void'(fq_size.pop_front());
    end
    if (hs_w && lw) b_pending = 1'b1;
    if (hs_b) begin
      b_pending = 1'b0;
      burst_idx++;
    end
    cyc++;
  endtask

  task automatic clear_models();
    fq_data.delete(); fq_size.delete(); exp_data.delete(); wbeats_q.delete();
    aw_addr_q.delete(); aw_len_q.delete(); wlast_q.delete();
    aw_wait = 0; burst_idx = 0; nbeat = 0; rd_viol = 0; stab_viol = 0;
    b_pending = 1'b0; aw_prev_valid = 1'b0;
  endtask

  task automatic reset_dut();
    sync_rst = 1'b1; cfg_start = 1'b0; record_finish = 1'b0;
    aw_delay = 0; wtoggle = 1'b0; err_burst = -1;
    clear_models();
    tick(); tick();
    sync_rst = 1'b0;
    clear_models();
  endtask

  task automatic preload(input int tag, input int n, input int last_size);
    logic [511:0] d;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = {8'(tag), 8'h5A, 16'(i)};
      fq_data.push_back(d);
      fq_size.push_back((i == n - 1) ? 32'(last_size) : 32'd512);
      exp_data.push_back(d);
    end
  endtask

  task automatic run_vec(input int v);
    vec_t t;
    int mism;
    t = vecs[v];
    reset_dut();
    preload(v + 1, t.nbeats, t.last_size);
    aw_delay = t.aw_delay; wtoggle = t.wtoggle; err_burst = t.err_burst;
    cfg_buf_base = t.base; cfg_buf_size = t.size;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int c = 1; c < 3000; c++) begin
      if (c == 20) record_finish = 1'b1;
      if (t.stray && c == 3) begin
        cfg_buf_base = 64'hDEAD_0000;
        cfg_start    = 1'b1;
      end
      tick();
      record_finish = 1'b0;
      cfg_start     = 1'b0;
      if (done) break;
    end
    chk($sformatf("v%0d_done", v), done, 1);
    for (int c = 0; c < 3; c++) tick();
    chk($sformatf("v%0d_bursts", v), aw_addr_q.size(), t.exp_bursts);
    if (aw_addr_q.size() >= 1) begin
      chk($sformatf("v%0d_awaddr0", v), aw_addr_q[0], t.exp_addr0);
      chk($sformatf("v%0d_awlen0", v), aw_len_q[0], t.exp_len0 - 1);
    end
    if (t.exp_bursts >= 2 && aw_addr_q.size() >= 2) begin
      chk($sformatf("v%0d_awaddr1", v), aw_addr_q[1], t.exp_addr1);
      chk($sformatf("v%0d_awlen1", v), aw_len_q[1], t.exp_len1 - 1);
    end
    chk($sformatf("v%0d_wlast_cnt", v), wlast_q.size(), t.exp_bursts);
    if (wlast_q.size() >= 1) chk($sformatf("v%0d_wlast0", v), wlast_q[0], t.exp_len0);
    if (t.exp_bursts >= 2 && wlast_q.size() >= 2)
      chk($sformatf("v%0d_wlast1", v), wlast_q[1], t.exp_len0 + t.exp_len1);
    chk($sformatf("v%0d_beats", v), wbeats_q.size(), t.nbeats - t.exp_left);
    mism = 0;
    for (int i = 0; i < wbeats_q.size() && i < exp_data.size(); i++)
      if (wbeats_q[i] !== exp_data[i]) mism++;
    chk($sformatf("v%0d_data_order", v), mism, 0);
    chk($sformatf("v%0d_bytes_written", v), bytes_written, t.exp_bytes);
    chk($sformatf("v%0d_bits_logged", v), bits_logged, t.exp_bits);
    chk($sformatf("v%0d_buf_full", v), buf_full, t.exp_buf_full);
    chk($sformatf("v%0d_resp_err", v), resp_err, t.exp_resp_err);
    chk($sformatf("v%0d_busy", v), busy, 0);
    chk($sformatf("v%0d_left", v), fq_data.size(), t.exp_left);
    chk($sformatf("v%0d_rd_en_hs", v), rd_viol, 0);
    chk($sformatf("v%0d_aw_stable", v), stab_viol, 0);
  endtask

  initial begin
    //          base      size        n   last ad tg err st  bu l0  l1  addr0     addr1     bytes     bits    bf re left
    vecs[0] = '{64'h1000, 32'h10000, 32, 512, 0, 0, -1, 1, 2, 16, 16, 64'h1000, 64'h1400, 32'h800, 64'd16384, 0, 0, 0};
    vecs[1] = '{64'h3000, 32'h10000,  5, 128, 0, 0, -1, 0, 1,  5,  0, 64'h3000, 64'h0,    32'h140, 64'd2176,  0, 0, 0};
    vecs[2] = '{64'h4000, 32'h400,   20, 512, 0, 0, -1, 0, 1, 16,  0, 64'h4000, 64'h0,    32'h400, 64'd8192,  1, 0, 4};
    vecs[3] = '{64'h8000, 32'h10000, 16, 512, 7, 1, -1, 0, 1, 16,  0, 64'h8000, 64'h0,    32'h400, 64'd8192,  0, 0, 0};
    vecs[4] = '{64'hA000, 32'h10000, 40, 512, 0, 0,  1, 0, 3, 16, 16, 64'hA000, 64'hA400, 32'hA00, 64'd20480, 0, 1, 0};

    sync_rst = 1'b1; cfg_start = 1'b0; record_finish = 1'b0;
    cfg_buf_base = '0; cfg_buf_size = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    cyc = 0; aw_delay = 0; wtoggle = 1'b0; err_burst = -1;
    clear_models();
    drive_fifo();
    @(negedge clk);

    reset_dut();
    #1;
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_bready", bready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_buf_full", buf_full, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_bytes", bytes_written, 0);
    chk("rst_bits", bits_logged, 0);
    chk("rst_awlen", awlen, 0);
    chk("awsize", awsize, 3'd6);
    chk("awburst", awburst, 2'b01);
    chk("wstrb", wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);

    for (int v = 0; v < 5; v++) run_vec(v);

    // Reset in the middle of the data phase, then restart from the base
    reset_dut();
    preload(9, 20, 512);
    cfg_buf_base = 64'h2000; cfg_buf_size = 32'h10000;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int c = 0; c < 200 && nbeat < 3; c++) tick();
    chk("midw_reached_beat3", nbeat, 3);
    chk("midw_bits_before", bits_logged, 64'd1536);
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    #1;
    chk("midw_awvalid", awvalid, 0);
    chk("midw_wvalid", wvalid, 0);
    chk("midw_rd_en", rd_en, 0);
    chk("midw_busy", busy, 0);
    chk("midw_bits", bits_logged, 0);
    chk("midw_awlen", awlen, 0);
    @(negedge clk);
    clear_models();
    preload(10, 16, 512);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int c = 0; c < 100 && aw_addr_q.size() == 0; c++) tick();
    chk("restart_aw_seen", aw_addr_q.size(), 1);
    if (aw_addr_q.size() > 0) begin
      chk("restart_awaddr", aw_addr_q[0], 64'h2000);
      chk("restart_awlen", aw_len_q[0], 8'd15);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_trace_writeback_ctrl.md
Name: rr_trace_writeback_ctrl

Overview:
- Drains the merged record-trace FIFO (AXI_WIDTH-bit beats plus valid-bit size) into a linear DRAM log buffer over an AXI4 write master.
- Sequences AW/W/B bursts with one burst outstanding, and issues full bursts while the record is in progress.
- On record finish, flushes the remaining beats as a short burst and reports the total logged bits.
- Sits between the trace-merge FIFO and the DDR AXI interconnect; configured by CSR logic.

Parameters:
- AXI_WIDTH, 512, data beat width in bits.
- AXI_ADDR_WIDTH, 64, AXI address width.
- OFFSET_WIDTH, 32, width of per-beat size and byte offsets.
- BURST_BEATS, 16, maximum beats per burst (power of 2, ≤ 64).
- FIFO_CNT_WIDTH, 10, width of the FIFO occupancy count.

Ports:
- clk  in  1  clock
- sync_rst  in  1  synchronous active-high reset
- cfg_start  in  1  pulse; latch config, begin logging
- cfg_buf_base  in  AXI_ADDR_WIDTH  buffer base, 4 KiB aligned
- cfg_buf_size  in  OFFSET_WIDTH  buffer bytes, multiple of BURST_BEATS*AXI_WIDTH/8
- record_finish  in  1  pulse; no further beats will be enqueued after FIFO drains
- record_out_fifo_dout  in  AXI_WIDTH  FWFT head data
- record_out_fifo_dout_size  in  OFFSET_WIDTH  valid bits in head beat
- record_out_fifo_empty  in  1
- record_out_fifo_cnt  in  FIFO_CNT_WIDTH  occupancy
- record_out_fifo_rd_en  out  1
- awvalid/awready  out/in  1
- awaddr  out  AXI_ADDR_WIDTH
- awlen  out  8
- awsize  out  3  constant log2(AXI_WIDTH/8)
- awburst  out  2  constant INCR
- wvalid/wready  out/in  1
- wdata  out  AXI_WIDTH  equals FIFO head data
- wstrb  out  AXI_WIDTH/8  all ones
- wlast  out  1
- bvalid/bready  in/out  1
- bresp  in  2
- busy  out  1  state is not IDLE or DONE
- done  out  1  sticky until cfg_start
- buf_full  out  1  sticky
- resp_err  out  1  sticky; any bresp ≠ OKAY
- bytes_written  out  OFFSET_WIDTH  byte offset of the next burst
- bits_logged  out  64  running sum of dout_size over consumed beats

Behaviour:
- Reset: state = IDLE. All valids, rd_en, done, buf_full, resp_err, busy and counters are 0; awlen = 0.
- IDLE: on cfg_start, latch base and size, clear counters and sticky flags, clear finish_seen, go to ARB. cfg_start in other states is ignored.
- finish_seen: set by record_finish in any non-IDLE state, including the same cycle a burst completes.
- ARB, evaluated in priority order:
  - bytes_written == buf_size and FIFO non-empty: set buf_full, go to DONE.
  - record_out_fifo_cnt ≥ BURST_BEATS: len = BURST_BEATS.
  - Otherwise, if finish_seen and FIFO non-empty: len = min(cnt, BURST_BEATS).
  - Otherwise, if finish_seen and FIFO empty: go to DONE.
  - Otherwise stay in ARB.
  - When a burst is chosen, register awaddr = base + bytes_written and awlen = len-1, and go to AW the next cycle.
- AW: hold awvalid until awready, then go to W. awaddr and awlen are stable while awvalid is high.
- W:
  - wvalid = ~record_out_fifo_empty.
  - record_out_fifo_rd_en = wvalid & wready, i.e. the beat is popped in the handshake cycle.
  - Beat counter compares against the latched len; wlast is asserted on beat len-1.
  - An empty FIFO mid-burst deasserts wvalid (cannot occur when len ≤ cnt; assert it).
  - bits_logged += dout_size on every pop. Partial bytes of the final beat are padding.
  - After the wlast handshake, go to B.
- B: bready = 1. On bvalid, bytes_written += len*AXI_WIDTH/8, OR resp_err with (bresp ≠ 0), go to ARB.
- DONE: done = 1, busy = 0, no AXI traffic; leave only on cfg_start.
- Width rules:
  - bytes_written is never allowed to exceed buf_size; the size constraint guarantees every burst fits.
  - Bursts never cross 4 KiB, given base alignment and burst bytes ≤ 4 KiB.
- Concurrency: only one AW is in flight; AW precedes W, so no W-before-AW.
- Reset mid-burst: abandons the transaction with no draining. The AXI slave is reset on the same domain.

Decomposition:
- rr_writeback_pkg holds:
  - state enum (IDLE, ARB, AW, W, B, DONE)
  - AXI_RESP_OKAY, AXI_BURST_INCR
  - a function bytes_per_beat(AXI_WIDTH)
- No sub-module. An optional sub-module rr_burst_len_calc (combinational min/compare) is allowed.

Test Plan:
- Streaming: base 0x1000, size 0x10000, 32 beats of 512 bits, immediate awready/wready/bvalid → two bursts, awaddr 0x1000 then 0x1400, awlen 15 each, wlast on beats 16 and 32, bytes_written 0x800.
- Flush: 5 beats, sizes 512,512,512,512,128, then record_finish → one burst, awlen 4, bits_logged 2176, done asserted after B.
- Buffer full: size 0x400 (one burst), 20 beats → one burst, then buf_full = 1, done = 1, 4 beats left in FIFO.
- Backpressure: wready toggling 1/0 every cycle, awready delayed 7 cycles → identical data order, rd_en only on handshakes, awaddr/awlen stable while awvalid.
- Error response: bresp = SLVERR on the second burst → resp_err sticky, logging continues.
- Reset mid-W: sync_rst pulsed at beat 3 → all outputs return to reset values the next cycle; a fresh cfg_start restarts at base.
